// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity receiver.
// SERIAL_PARITY_ODD_EN selects odd (defined) or even (undefined) parity.
package serial_parity_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

`ifdef SERIAL_PARITY_ODD_EN
  localparam logic PAR_EXP = 1'b1;
`else
  localparam logic PAR_EXP = 1'b0;
`endif

  // acc is the XOR of all data bits and the parity bit
  function automatic logic par_bad(input logic acc);
    return acc != PAR_EXP;
  endfunction

endpackage

// File: rtl/serial_parity_shreg.sv
// LSB-first shift register: new bits enter at the MSB and move down.
// Ports: clk, rst (sync), clr, en, din -> q (W bits).
module serial_parity_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[W-1:1]};
    end
  end

endmodule

// File: rtl/serial_parity_receiver.sv
// Serial frame receiver: start, DATA_W bits LSB-first, parity, stop.
// Ports: clk, rst, sin, bit_en in; dout, dvalid, perr, ferr, busy out.
// Parity sense set by SERIAL_PARITY_ODD_EN (see serial_parity_pkg).
module serial_parity_receiver
  import serial_parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              bit_en,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              perr,
  output logic              ferr,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DATA_W - 1);

  rx_state_t         state;
  rx_state_t         state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic              par;
  logic              par_nx;
  logic [DATA_W-1:0] dout_nx;
  logic              dvalid_nx;
  logic              perr_nx;
  logic              ferr_nx;
  logic              sh_clr;
  logic              sh_en;
  logic [DATA_W-1:0] sh_q;

  serial_parity_shreg #(
    .W (DATA_W)
  ) u_shreg (
    .clk (clk),
    .rst (rst),
    .clr (sh_clr),
    .en  (sh_en),
    .din (sin),
    .q   (sh_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      par    <= 1'b0;
      dout   <= '0;
      dvalid <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      par    <= par_nx;
      dout   <= dout_nx;
      dvalid <= dvalid_nx;
      perr   <= perr_nx;
      ferr   <= ferr_nx;
    end
  end

  // Everything but dvalid holds while bit_en is low;
  // dvalid always drops after one cycle.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    par_nx    = par;
    dout_nx   = dout;
    dvalid_nx = 1'b0;
    perr_nx   = perr;
    ferr_nx   = ferr;
    sh_clr    = 1'b0;
    sh_en     = 1'b0;
    if (bit_en) begin
      unique case (state)
        IDLE: begin
          if (!sin) begin
            state_nx = DATA;
            cnt_nx   = '0;
            par_nx   = 1'b0;
            sh_clr   = 1'b1;
          end
        end
        DATA: begin
          sh_en  = 1'b1;
          par_nx = par ^ sin;
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state_nx = PARITY;
          end
        end
        PARITY: begin
          par_nx   = par ^ sin;
          state_nx = STOP;
        end
        STOP: begin
          // no start-bit check here; IDLE sees the next 0
          dout_nx   = sh_q;
          dvalid_nx = 1'b1;
          perr_nx   = par_bad(par);
          ferr_nx   = ~sin;
          state_nx  = IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Scoreboard bench for serial_parity_receiver (DATA_W=8).
// Directed frames plus randomized frames, stalls and errors.
module tb_serial_parity_receiver;

  localparam int W = 8;

`ifdef SERIAL_PARITY_ODD_EN
  localparam logic ODD_EXP = 1'b1;
`else
  localparam logic ODD_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         p;
    logic         f;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         sin;
  logic         bit_en;
  logic [W-1:0] dout;
  logic         dvalid;
  logic         perr;
  logic         ferr;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int pulses = 0;

  exp_t sb[$];

  always #5 clk = ~clk;

  serial_parity_receiver #(
    .DATA_W (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sin    (sin),
    .bit_en (bit_en),
    .dout   (dout),
    .dvalid (dvalid),
    .perr   (perr),
    .ferr   (ferr),
    .busy   (busy)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Overall XOR of data plus parity bit, via a ones count
  function automatic logic model_perr(input logic [W-1:0] d,
                                      input logic pb);
    int ones;
    logic odd;
    ones = $countones(d) + int'(pb);
    odd = (ones % 2) == 1;
    return odd != ODD_EXP;
  endfunction

  function automatic logic good_pbit(input logic [W-1:0] d);
    int ones;
    ones = $countones(d);
    return ((ones % 2) == 1) != ODD_EXP;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int stall);
    sin = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    repeat (stall) begin
      sin = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d,
                            input logic pb,
                            input logic stop,
                            input int stall,
                            input int idle);
    exp_t e;
    e.d = d;
    e.p = model_perr(d, pb);
    e.f = ~stop;
    sb.push_back(e);
    frames++;
    drive_bit(1'b0, stall);
    for (int i = 0; i < W; i++) begin
      drive_bit(d[i], stall);
    end
    drive_bit(pb, stall);
    drive_bit(stop, stall);
    sin = 1'b1;
    bit_en = 1'b1;
    repeat (idle) tick();
  endtask

  // Monitor: pops on every dvalid, otherwise checks outputs hold
  logic [W-1:0] last_d = '0;
  logic         last_p = 1'b0;
  logic         last_f = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_d = '0;
        last_p = 1'b0;
        last_f = 1'b0;
      end else if (dvalid) begin
        pulses++;
        check("frame_queued", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("dout", 32'(dout), 32'(e.d));
          check("perr", 32'(perr), 32'(e.p));
          check("ferr", 32'(ferr), 32'(e.f));
        end
        last_d = dout;
        last_p = perr;
        last_f = ferr;
      end else begin
        check("hold_dout", 32'(dout), 32'(last_d));
        check("hold_perr", 32'(perr), 32'(last_p));
        check("hold_ferr", 32'(ferr), 32'(last_f));
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    logic         pb;
    logic         st;
    rst = 1'b1;
    sin = 1'b0;
    bit_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sin = 1'b1;
    rst = 1'b0;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    send_frame(8'hA5, 1'b0, 1'b1, 0, 2);
    send_frame(8'hA5, 1'b1, 1'b1, 0, 2);
    send_frame(8'h07, 1'b0, 1'b1, 0, 2);
    send_frame(8'h3C, good_pbit(8'h3C), 1'b0, 0, 2);
    send_frame(8'h5A, good_pbit(8'h5A), 1'b1, 3, 2);

    // abort after 4th data bit; rst wins over bit_en
    drive_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'($urandom), 0);
    end
    check("busy_midframe", 32'(busy), 32'd1);
    rst = 1'b1;
    sin = 1'b1;
    bit_en = 1'b1;
    tick();
    rst = 1'b0;
    check("busy_after_rst", 32'(busy), 32'd0);
    check("dvalid_after_rst", 32'(dvalid), 32'd0);
    send_frame(8'h81, good_pbit(8'h81), 1'b1, 0, 2);

    for (int n = 0; n < 40; n++) begin
      d = W'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? ~good_pbit(d)
                                       : good_pbit(d);
      st = ($urandom_range(0, 4) != 0);
      send_frame(d, pb, st, $urandom_range(0, 2),
                 $urandom_range(0, 2));
    end

    sin = 1'b1;
    bit_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      tick();
    end
    repeat (3) tick();
    check("queue_drained", 32'(sb.size()), 32'd0);
    check("dvalid_count", 32'(pulses), 32'(frames));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_parity_receiver.md
SERIAL_PARITY_RECEIVER -- requirements
Module: serial_parity_receiver

Interface
REQ-001 SHALL have parameter: DATA_W, 8, number of data bits per frame (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: sin  input  1  serial line; idle level 1.
REQ-005 SHALL have port: bit_en  input  1  bit strobe; sin is sampled only on rising clk edges where bit_en=1.
REQ-006 SHALL have port: dout  output  DATA_W  last received data word.
REQ-007 SHALL have port: dvalid  output  1  one-cycle pulse marking a completed frame.
REQ-008 SHALL have port: perr  output  1  parity error for the frame flagged by dvalid.
REQ-009 SHALL have port: ferr  output  1  framing (stop-bit) error for the frame flagged by dvalid.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL use frame format: start bit (0), DATA_W data bits LSB-first, one parity bit, one stop bit (1).
REQ-012 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-013 SHALL, in IDLE, go to DATA on a sampled sin=0 and stay in IDLE on a sampled sin=1.
REQ-014 SHALL, in DATA, shift each sampled bit into the data register LSB-first, XOR it into the running parity, and go to PARITY after the DATA_W-th bit.
REQ-015 SHALL, in PARITY, XOR the sampled parity bit into the running parity and go to STOP.
REQ-016 SHALL, in STOP, on the sampling edge: load dout with the data register, set dvalid=1, set perr=(running parity != expected), set ferr=(sin==0), and go to IDLE.
REQ-017 SHALL drive dvalid high for exactly one cycle, in the cycle after the stop-bit sampling edge; perr and ferr SHALL hold until the next dvalid.
REQ-018 SHALL hold all state, the bit counter and the running parity unchanged on edges where bit_en=0 (stall, any length).
REQ-019 SHALL still pulse dvalid on erroneous frames, with perr and/or ferr qualifying the frame.
REQ-020 SHALL hold dout between frames; only REQ-016 updates it.
REQ-021 SHALL not re-check for a start bit in the same edge that samples the stop bit; a new frame starts at the next sampled 0.
REQ-022 SHALL use a bit counter of $clog2(DATA_W+1) bits, cleared on entry to DATA.

Reset
REQ-023 SHALL, when rst=1 on a clk edge, set state=IDLE, dout=0, dvalid=0, perr=0, ferr=0, busy=0, counter=0, running parity=0.
REQ-024 SHALL discard a frame in progress when rst is asserted mid-frame, with no dvalid pulse for it.
REQ-025 SHALL give rst priority over bit_en in the same cycle.

Configuration
REQ-026 SHALL use macro SERIAL_PARITY_ODD_EN: if undefined, expected overall parity of data plus parity bit is even (XOR=0); if defined, expected parity is odd (XOR=1).

Structure
REQ-027 SHALL place the FSM state enum and the DATA_W default constant in package serial_parity_pkg.
REQ-028 SHALL implement the LSB-first shift register with enable and clear as sub-module serial_parity_shreg.

Verification (DATA_W=8, bit_en=1 unless stated)
REQ-029 SHALL test: macro off, frame 0xA5, parity bit 0, stop 1 -> one dvalid pulse, dout=0xA5, perr=0, ferr=0.
REQ-030 SHALL test: macro off, frame 0x07, parity bit 0 -> dout=0x07, perr=1, ferr=0.
REQ-031 SHALL test: frame 0x3C, correct parity, stop bit 0 -> dout=0x3C, perr=0, ferr=1.
REQ-032 SHALL test: frame 0x5A with bit_en=0 for 3 cycles between every bit -> same result as bit_en=1 throughout (dout=0x5A, no errors), dvalid exactly once.
REQ-033 SHALL test: rst for one cycle after the 4th data bit, then full frame 0x81 -> only one dvalid, dout=0x81, busy=0 directly after reset.
REQ-034 SHALL test: macro on, frame 0xA5, parity bit 1 -> perr=0; same frame with parity bit 0 -> perr=1.
